// File: rtl/urf_pkg.sv
// Shared types and constants for the universal register array initiator.
package urf_pkg;

    localparam int URF_STATUS_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RDATA = 2'b10,
        RESP  = 2'b11
    } urf_state_e;

    typedef enum logic [URF_STATUS_W-1:0] {
        ST_OK       = 2'b00,
        ST_ADDR_ERR = 2'b01,
        ST_TIMEOUT  = 2'b10
    } urf_status_e;

    // Counter width able to hold the value TIMEOUT itself.
    function automatic int urf_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/urf_busy_timer.sv
// Purpose: saturating count of consecutive busy cycles seen while a strobe is held.
// Latency: expired is combinational on inc and the current count.
// Backpressure: none; the count saturates at TIMEOUT and never wraps.
module urf_busy_timer
    import urf_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = urf_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // High on the busy edge that would bring the count up to TIMEOUT.
    assign expired = inc && (cnt_q >= LAST);

endmodule

// File: rtl/urf_initiator.sv
// Purpose: single-command initiator driving the register array strobes from a valid/ready command channel.
// Latency: write OK response 2 cycles after handshake, read 3, ADDR_ERR 1; each busy cycle adds one.
// Backpressure: one command in flight; cmd_ready stays low until the response has been taken.
module urf_initiator
    import urf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [URF_STATUS_W-1:0] rsp_status,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    write_en,
    output logic                    read_en,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    busy
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    urf_state_e             state_q, state_d;
    urf_status_e            status_q, status_d;
    logic                   op_q, op_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   cmd_ready_q;
    logic                   tmr_clr;
    logic                   tmr_inc;
    logic                   tmr_expired;

    urf_busy_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_busy_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    if (cmd_addr >= DEPTH_A) begin
                        state_d  = RESP;
                        status_d = ST_ADDR_ERR;
                    end else begin
                        state_d  = ISSUE;
                        status_d = ST_OK;
                        tmr_clr  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Acceptance is checked first so a busy drop on the expiry edge still completes.
                if (!busy) begin
                    state_d  = op_q ? RESP : RDATA;
                    status_d = ST_OK;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expired) begin
                        state_d  = RESP;
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            RDATA: begin
                rdata_d  = read_data;
                status_d = ST_OK;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            status_q    <= ST_OK;
            op_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            // Registered so it is low throughout reset and rises one cycle after release.
            cmd_ready_q <= (state_d == IDLE);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign write_en   = (state_q == ISSUE) && op_q;
    assign read_en    = (state_q == ISSUE) && !op_q;
    assign write_addr = addr_q;
    assign read_addr  = addr_q;
    assign write_data = wdata_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_write  = op_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

    strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(write_en && read_en));

    resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_status) && $stable(rsp_rdata)));

endmodule

// File: tb/tb_urf_initiator.sv
// Directed bench for urf_initiator with a behavioural 32-entry register array model.
module tb_urf_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic [31:0] write_addr;
    logic [31:0] read_addr;
    logic [7:0]  write_data;
    logic        write_en;
    logic        read_en;
    logic [7:0]  read_data;
    logic        busy;

    int n_chk;
    int n_fail;

    logic [7:0] mem [0:31];

    urf_initiator #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (32),
        .DEPTH      (32),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .write_addr (write_addr),
        .read_addr  (read_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .read_data  (read_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: strobe accepted when high with busy low; read data valid the next cycle only.
    always @(posedge clk) begin
        if (write_en && !busy && (write_addr < 32))
            mem[write_addr[4:0]] <= write_data;
        read_data <= (read_en && !busy) ? mem[read_addr[4:0]] : 8'hEE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issues one command at a negedge with cmd_ready high; returns at the negedge where rsp_valid is seen.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                          input int nbusy, output int rsp_cyc, output int we_n, output int re_n);
        int cyc;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_before_cmd: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        rsp_cyc   = -1;
        we_n      = 0;
        re_n      = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            busy = (cyc <= nbusy);
            if (write_en) we_n++;
            if (read_en) re_n++;
            if (write_en || read_en) begin
                n_chk++;
                if (write_addr !== addr || read_addr !== addr || (wr && write_data !== wd)) begin
                    n_fail++;
                    $display("FAIL strobe_addr: got wa=%0h ra=%0h wd=%0h want a=%0h d=%0h",
                             write_addr, read_addr, write_data, addr, wd);
                end
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        busy = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({cmd_ready, rsp_valid, write_en, read_en, rsp_write, rsp_status, rsp_rdata,
             write_addr, read_addr, write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b we=%b re=%b st=%0h wa=%0h want all 0",
                     cmd_ready, rsp_valid, write_en, read_en, rsp_status, write_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int rc, wn, rn;
        do_cmd(1'b1, 32'd3, 8'hA5, 0, rc, wn, rn);
        n_chk++;
        if (rc !== 2 || wn !== 1 || rn !== 0) begin
            n_fail++;
            $display("FAIL write_timing: got rsp_cyc=%0d we=%0d re=%0d want 2 1 0", rc, wn, rn);
        end
        n_chk++;
        if (rsp_status !== 2'b00 || rsp_write !== 1'b1 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL write_rsp: got st=%0h w=%b rd=%0h want 0 1 0", rsp_status, rsp_write, rsp_rdata);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp_hold: got rv=%b st=%0h rdy=%b want 1 0 0", rsp_valid, rsp_status, cmd_ready);
        end
        finish_rsp();
        n_chk++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_rsp_leave: got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        int rc, wn, rn;
        do_cmd(1'b0, 32'd3, 8'h00, 0, rc, wn, rn);
        n_chk++;
        if (rc !== 3 || wn !== 0 || rn !== 1) begin
            n_fail++;
            $display("FAIL read_timing: got rsp_cyc=%0d we=%0d re=%0d want 3 0 1", rc, wn, rn);
        end
        n_chk++;
        if (rsp_rdata !== 8'hA5 || rsp_status !== 2'b00 || rsp_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp: got rd=%0h st=%0h w=%b want a5 0 0", rsp_rdata, rsp_status, rsp_write);
        end
        finish_rsp();
    endtask

    task automatic test_addr_err();
        int rc, wn, rn;
        do_cmd(1'b0, 32'd32, 8'h00, 0, rc, wn, rn);
        n_chk++;
        if (rc !== 1 || wn !== 0 || rn !== 0 || rsp_status !== 2'b01 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL addr_err_read: got rc=%0d we=%0d re=%0d st=%0h rd=%0h want 1 0 0 1 0",
                     rc, wn, rn, rsp_status, rsp_rdata);
        end
        finish_rsp();
        do_cmd(1'b1, 32'hFFFF_FFFF, 8'h11, 0, rc, wn, rn);
        n_chk++;
        if (rc !== 1 || wn !== 0 || rsp_status !== 2'b01 || rsp_write !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_err_write: got rc=%0d we=%0d st=%0h w=%b want 1 0 1 1", rc, wn, rsp_status, rsp_write);
        end
        finish_rsp();
        do_cmd(1'b1, 32'd31, 8'h3C, 0, rc, wn, rn);
        finish_rsp();
        do_cmd(1'b0, 32'd31, 8'h00, 0, rc, wn, rn);
        n_chk++;
        if (rc !== 3 || rsp_status !== 2'b00 || rsp_rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL last_addr: got rc=%0d st=%0h rd=%0h want 3 0 3c", rc, rsp_status, rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_busy();
        int rc, wn, rn;
        do_cmd(1'b1, 32'd7, 8'h5A, 4, rc, wn, rn);
        n_chk++;
        if (rc !== 6 || wn !== 5 || rsp_status !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_write: got rc=%0d we=%0d st=%0h want 6 5 0", rc, wn, rsp_status);
        end
        finish_rsp();
        do_cmd(1'b0, 32'd7, 8'h00, 2, rc, wn, rn);
        n_chk++;
        if (rc !== 5 || rn !== 3 || rsp_rdata !== 8'h5A || rsp_status !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_read: got rc=%0d re=%0d rd=%0h st=%0h want 5 3 5a 0", rc, rn, rsp_rdata, rsp_status);
        end
        finish_rsp();
        // busy drops exactly on the edge that would otherwise expire the command
        do_cmd(1'b1, 32'd8, 8'h42, 15, rc, wn, rn);
        n_chk++;
        if (rc !== 17 || wn !== 16 || rsp_status !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_edge: got rc=%0d we=%0d st=%0h want 17 16 0", rc, wn, rsp_status);
        end
        finish_rsp();
    endtask

    task automatic test_timeout();
        int rc, wn, rn;
        do_cmd(1'b1, 32'd9, 8'h77, 1000, rc, wn, rn);
        n_chk++;
        if (rc !== 17 || wn !== 16 || rsp_status !== 2'b10 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL timeout_write: got rc=%0d we=%0d st=%0h rd=%0h want 17 16 2 0", rc, wn, rsp_status, rsp_rdata);
        end
        finish_rsp();
        do_cmd(1'b0, 32'd3, 8'h00, 1000, rc, wn, rn);
        n_chk++;
        if (rc !== 17 || rn !== 16 || rsp_status !== 2'b10 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL timeout_read: got rc=%0d re=%0d st=%0h rd=%0h want 17 16 2 0", rc, rn, rsp_status, rsp_rdata);
        end
        finish_rsp();
        do_cmd(1'b0, 32'd9, 8'h00, 0, rc, wn, rn);
        n_chk++;
        if (rsp_rdata !== 8'h00 || rsp_status !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_no_write: got rd=%0h st=%0h want 0 0", rsp_rdata, rsp_status);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int hs, nr, rc, wn, rn;
        hs = 0;
        nr = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd5;
        cmd_wdata = 8'h10;
        rsp_ready = 1'b1;
        busy      = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (cmd_valid && cmd_ready) hs++;
            if (rsp_valid) nr++;
            @(negedge clk);
            cmd_wdata = 8'h10 + 8'(hs);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_chk++;
        if (hs !== 3 || nr !== 3) begin
            n_fail++;
            $display("FAIL back_to_back_rate: got hs=%0d rsp=%0d in 9 cycles want 3 3", hs, nr);
        end
        do_cmd(1'b0, 32'd5, 8'h00, 0, rc, wn, rn);
        n_chk++;
        if (rsp_rdata !== 8'h12) begin
            n_fail++;
            $display("FAIL back_to_back_data: got %0h want 12", rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int stale;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd4;
        cmd_wdata = 8'h99;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++;
        if (write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_issue: got we=%b want 1", write_en);
        end
        busy  = 1'b1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, rsp_valid, write_en, read_en, write_addr, write_data, rsp_status} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got rdy=%b rv=%b we=%b re=%b wa=%0h want all 0",
                     cmd_ready, rsp_valid, write_en, read_en, write_addr);
        end
        @(negedge clk);
        busy  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b want 1", cmd_ready);
        end
        stale = 0;
        repeat (5) begin
            if (rsp_valid || write_en || read_en) stale++;
            @(negedge clk);
        end
        n_chk++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_stale: got %0d active cycles want 0", stale);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_addr_err();
        test_busy();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/urf_initiator.md
# urf_initiator

Bus-side initiator for the universal register array (`universal_reg_array`). It accepts single read/write commands on a valid/ready command channel and drives the array's `write_en`/`read_en`, `write_addr`/`read_addr` and `write_data` ports. It honours the array's `busy` back-pressure, captures `read_data`, and returns one response per command on a valid/ready response channel with a status code. It replaces ad-hoc testbench stimulus as the only agent allowed to drive the array.

## Interface
- `DATA_WIDTH`, 8: data width; must match the array.
- `ADDR_WIDTH`, 32: width of the address ports.
- `DEPTH`, 32: number of array entries; legal addresses are 0..DEPTH-1.
- `TIMEOUT`, 16: maximum number of consecutive busy cycles tolerated per command; minimum 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: initiator can take a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: target address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumer ready.
- `rsp_write` out 1: echo of `cmd_write`.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_status` out 2: 00 OK, 01 ADDR_ERR, 10 TIMEOUT.
- `write_addr`, `read_addr` out ADDR_WIDTH: address to the array.
- `write_data` out DATA_WIDTH: data to the array.
- `write_en`, `read_en` out 1: strobes to the array.
- `read_data` in DATA_WIDTH: array read data.
- `busy` in 1: array cannot accept a strobe this cycle.

## Operation
- Array contract: a strobe is accepted at a rising edge where the strobe is high and `busy` is 0. Read data is valid in the cycle after acceptance.
- FSM states: IDLE, ISSUE, RDATA, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register op, addr and wdata.
  - If addr ≥ DEPTH, go to RESP with ADDR_ERR; no strobe is issued.
  - Otherwise go to ISSUE and clear the busy counter.
- ISSUE:
  - Drive exactly one of `write_en`/`read_en` high, with registered addr/data.
  - If `busy`=0 at the edge: a write goes to RESP with OK; a read goes to RDATA.
  - If `busy`=1: increment the busy counter. When the counter reaches TIMEOUT, drop the strobe and go to RESP with TIMEOUT.
- RDATA:
  - Strobes are low.
  - Capture `read_data` into `rsp_rdata` at the edge, then go to RESP with OK.
- RESP:
  - `rsp_valid`=1; all response fields are held stable.
  - On `rsp_ready`, go to IDLE.
- Strobes are never both high. Each strobe is high only in ISSUE.
- `write_addr` and `read_addr` both carry the registered address. They and `write_data` hold their last value between commands.
- Busy counter is ⌈log2(TIMEOUT+1)⌉ bits and saturates; it never wraps.

## Timing
- Reset values: every output is 0 and the state is IDLE. `cmd_ready` goes to 1 in the first cycle after deassertion.
- Assertion of `rst_n` low mid-command: strobes drop combinationally-free (reset is applied directly to the registers). No response is produced for the aborted command.
- Write with no busy: handshake at cycle 0 → `write_en` high in cycle 1 → `rsp_valid` in cycle 2.
- Read with no busy: handshake at cycle 0 → `read_en` in cycle 1 → RDATA in cycle 2 → `rsp_valid` in cycle 3.
- Each busy cycle adds one cycle of latency, up to TIMEOUT cycles.
- ADDR_ERR: `rsp_valid` in cycle 1.
- `cmd_ready` is 0 from the handshake until the cycle after the `rsp_ready` handshake. Peak throughput is one write every 3 cycles.
- Simultaneous events:
  - `busy` falling on the same edge the counter would hit TIMEOUT: acceptance wins and the status is OK.
  - `rsp_ready` held high in RESP: leave after one cycle.

## Structure
- Package `urf_pkg`: `urf_state_e` (IDLE/ISSUE/RDATA/RESP), `urf_status_e` (OK/ADDR_ERR/TIMEOUT), and status width constant `URF_STATUS_W`=2.
- Sub-module `urf_busy_timer`: saturating busy counter with clear, increment and `expired` output.

## Test plan
- Write 0xA5 to addr 3 with `busy`=0 → `write_en` high for exactly 1 cycle with `write_addr`=3; `rsp_valid` at cycle 2 with status 00.
- Read addr 3 after that write → `read_en` for 1 cycle; `rsp_rdata`=0xA5, status 00, `rsp_valid` at cycle 3.
- Read addr 32 (DEPTH=32) → no strobe; `rsp_valid` at cycle 1 with status 01 and `rsp_rdata`=0.
- Hold `busy`=1 for 4 cycles during a write → `write_en` held 5 cycles; status 00.
- Hold `busy`=1 permanently (TIMEOUT=16) → strobe drops after 16 cycles; status 10.
- Pull `rst_n` low while in ISSUE and hold `rsp_ready`=0 → all outputs 0 immediately; after reset release, `cmd_ready`=1 and no stale response appears.
